uart_rx: RTL and testbench

Serial receiver for the 8N1-style asynchronous link: oversamples an idle-high serial line, detects the start bit, samples each data bit at its midpoint, checks the stop bit and presents the received word as a one-cycle parallel strobe. It is the reader end of the serial link that our shift-register transmitter drives, and it sits between a board pin and the parallel datapath.

---
 rtl/uart_rx_if.sv | 29 ++
 rtl/uart_rx.sv | 142 ++++++++++++++
 tb/tb_uart_rx.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Parallel-side and line-side signals of the serial receiver.
// The master modport is the receiver itself, which consumes the serial line
// and presents the received words. The slave modport is the other end: it
// drives the line and observes the received words.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_i;
    logic [DATA_BITS-1:0] data_o;
    logic                 valid_o;
    logic                 frame_err_o;
    logic                 busy_o;

    modport master (
        input  rx_i,
        output data_o,
        output valid_o,
        output frame_err_o,
        output busy_o
    );

    modport slave (
        output rx_i,
        input  data_o,
        input  valid_o,
        input  frame_err_o,
        input  busy_o
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling 8N1-style serial receiver.
// The idle-high line is synchronised and the falling edge of the start bit is
// detected. The start bit is re-checked at its midpoint, and each data bit is
// then sampled one full bit period later (LSB first). The stop bit is checked
// at its midpoint. A good frame updates data_o with a one-cycle valid_o pulse.
// A low stop bit gives a one-cycle frame_err_o pulse and parks the receiver
// until the line returns high.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_rx_if.master bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam int H  = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MID  = CW'(H - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    state_t               state_r;
    logic                 rx_meta_r;
    logic                 rx_sync_r;
    logic [CW-1:0]        cnt_r;
    logic [IW-1:0]        idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] data_r;
    logic                 valid_r;
    logic                 ferr_r;

    // Two-flop synchroniser for the asynchronous line; resets to the idle level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= bus.rx_i;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Frame FSM: the counter, bit index, shift register and registered output pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            idx_r   <= IDX_ZERO;
            shift_r <= {DATA_BITS{1'b0}};
            data_r  <= {DATA_BITS{1'b0}};
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= CNT_ZERO;
                    if (!rx_sync_r) begin
                        state_r <= ST_START;
                    end
                end
                ST_START: begin
                    // Re-check the start bit at its midpoint. From here on,
                    // every sample lands one full bit later.
                    if (cnt_r == CNT_MID) begin
                        cnt_r <= CNT_ZERO;
                        if (rx_sync_r) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_DATA;
                            idx_r   <= IDX_ZERO;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= CNT_ZERO;
                        shift_r <= {rx_sync_r, shift_r[DATA_BITS-1:1]};
                        idx_r   <= idx_r + IDX_ONE;
                        if (idx_r == IDX_LAST) begin
                            state_r <= ST_STOP;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    // Decide at the stop midpoint and return straight away,
                    // so that a following start bit is not missed.
                    if (cnt_r == CNT_LAST) begin
                        cnt_r <= CNT_ZERO;
                        if (rx_sync_r) begin
                            data_r  <= shift_r;
                            valid_r <= 1'b1;
                            state_r <= ST_IDLE;
                        end else begin
                            ferr_r  <= 1'b1;
                            state_r <= ST_BREAK;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_BREAK: begin
                    // A line held low must go high again before a new start is accepted.
                    cnt_r <= CNT_ZERO;
                    if (rx_sync_r) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign bus.data_o      = data_r;
    assign bus.valid_o     = valid_r;
    assign bus.frame_err_o = ferr_r;
    assign bus.busy_o      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx. The stimulus sends directed frames and pushes
// the expected pulse (kind, data, cycle) into a queue. A monitor pops the
// queue and compares whenever a DUT raises valid_o or frame_err_o.
// DUT a uses the default parameters and DUT b uses CLKS_PER_BIT = 4.
module tb_uart_rx;

    typedef struct {
        bit         ferr;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t qa[$];
    exp_t qb[$];
    logic [7:0] lg_a = 8'h00;
    logic [7:0] lg_b = 8'h00;

    uart_rx_if #(.DATA_BITS(8)) ifa ();
    uart_rx_if #(.DATA_BITS(8)) ifb ();

    uart_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    uart_rx #(.CLKS_PER_BIT(4),  .DATA_BITS(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for DUT a.
    always @(negedge clk) begin
        exp_t e;
        if (ifa.valid_o === 1'b1 || ifa.frame_err_o === 1'b1) begin
            if (qa.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse_a: got valid=%b ferr=%b expected none (cycle %0d)",
                         ifa.valid_o, ifa.frame_err_o, cyc);
            end else begin
                e = qa.pop_front();
                chk("kind_a", {30'd0, ifa.valid_o, ifa.frame_err_o}, e.ferr ? 32'd1 : 32'd2);
                chk("data_a", {24'd0, ifa.data_o}, {24'd0, e.data});
                chk("cycle_a", cyc, e.cyc);
            end
        end
    end

    // Monitor for DUT b.
    always @(negedge clk) begin
        exp_t e;
        if (ifb.valid_o === 1'b1 || ifb.frame_err_o === 1'b1) begin
            if (qb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse_b: got valid=%b ferr=%b expected none (cycle %0d)",
                         ifb.valid_o, ifb.frame_err_o, cyc);
            end else begin
                e = qb.pop_front();
                chk("kind_b", {30'd0, ifb.valid_o, ifb.frame_err_o}, e.ferr ? 32'd1 : 32'd2);
                chk("data_b", {24'd0, ifb.data_o}, {24'd0, e.data});
                chk("cycle_b", cyc, e.cyc);
            end
        end
    end

    task automatic send_bit(input bit sel, input logic b, input int cpb);
        if (sel) ifb.rx_i = b;
        else     ifa.rx_i = b;
        repeat (cpb) @(negedge clk);
    endtask

    // Call at a negedge. Edge 0 is the next posedge. The pulse is expected
    // after edge 2 + H + 9*cpb.
    task automatic send_frame(input bit sel, input logic [7:0] d, input logic stop, input int cpb);
        exp_t e;
        e.ferr = ~stop;
        e.data = stop ? d : (sel ? lg_b : lg_a);
        e.cyc  = cyc + 1 + 2 + cpb / 2 + 9 * cpb;
        if (stop) begin
            if (sel) lg_b = d;
            else     lg_a = d;
        end
        if (sel) qb.push_back(e);
        else     qa.push_back(e);
        send_bit(sel, 1'b0, cpb);
        for (int i = 0; i < 8; i++) send_bit(sel, d[i], cpb);
        send_bit(sel, stop, cpb);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data_a"},  {24'd0, ifa.data_o}, 32'd0);
        chk({tag, "_valid_a"}, {31'd0, ifa.valid_o}, 32'd0);
        chk({tag, "_ferr_a"},  {31'd0, ifa.frame_err_o}, 32'd0);
        chk({tag, "_busy_a"},  {31'd0, ifa.busy_o}, 32'd0);
        chk({tag, "_data_b"},  {24'd0, ifb.data_o}, 32'd0);
        chk({tag, "_busy_b"},  {31'd0, ifb.busy_o}, 32'd0);
    endtask

    initial begin
        int busy_drop;
        rst_n    = 1'b0;
        ifa.rx_i = 1'b1;
        ifb.rx_i = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single good frame 0xA5.
        send_frame(1'b0, 8'hA5, 1'b1, 16);
        repeat (2) @(negedge clk);
        chk("a5_busy_after", {31'd0, ifa.busy_o}, 32'd0);
        chk("a5_data_held", {24'd0, ifa.data_o}, 32'h0000_00A5);

        // Back-to-back frames with no idle gap.
        send_frame(1'b0, 8'h00, 1'b1, 16);
        send_frame(1'b0, 8'hFF, 1'b1, 16);
        send_frame(1'b0, 8'h3C, 1'b1, 16);
        repeat (4) @(negedge clk);

        // A 4-cycle glitch is rejected at the start midpoint.
        ifa.rx_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("glitch_busy_rise", {31'd0, ifa.busy_o}, 32'd1);
        ifa.rx_i = 1'b1;
        repeat (6) @(negedge clk);
        chk("glitch_busy_last", {31'd0, ifa.busy_o}, 32'd1);
        @(negedge clk);
        chk("glitch_busy_fall", {31'd0, ifa.busy_o}, 32'd0);
        repeat (20) @(negedge clk);
        chk("glitch_data_held", {24'd0, ifa.data_o}, 32'h0000_003C);

        // Good 0x5A, then 0x81 with a low stop bit, and the line held low.
        send_frame(1'b0, 8'h5A, 1'b1, 16);
        send_frame(1'b0, 8'h81, 1'b0, 16);
        busy_drop = 0;
        repeat (40) begin
            @(negedge clk);
            if (ifa.busy_o !== 1'b1) busy_drop++;
        end
        chk("break_busy_hold", busy_drop, 32'd0);
        ifa.rx_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("break_busy_last", {31'd0, ifa.busy_o}, 32'd1);
        @(negedge clk);
        chk("break_busy_fall", {31'd0, ifa.busy_o}, 32'd0);
        chk("break_data_held", {24'd0, ifa.data_o}, 32'h0000_005A);
        repeat (10) @(negedge clk);

        // Reset in the middle of data bit 3 discards the partial frame.
        send_bit(1'b0, 1'b0, 16);
        send_bit(1'b0, 1'b1, 16);
        send_bit(1'b0, 1'b1, 16);
        send_bit(1'b0, 1'b0, 16);
        ifa.rx_i = 1'b1;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        lg_a = 8'h00;
        lg_b = 8'h00;
        chk_reset_outputs("midreset");
        repeat (200) @(negedge clk);
        send_frame(1'b0, 8'hC3, 1'b1, 16);
        repeat (4) @(negedge clk);
        chk("c3_data_held", {24'd0, ifa.data_o}, 32'h0000_00C3);

        // Short bit period on DUT b.
        send_frame(1'b1, 8'h96, 1'b1, 4);
        repeat (4) @(negedge clk);
        chk("b96_busy_after", {31'd0, ifb.busy_o}, 32'd0);

        repeat (20) @(negedge clk);
        chk("pending_a", qa.size(), 32'd0);
        chk("pending_b", qb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
